dmem_port_arbiter: RTL and testbench

- Shares the single-port 32-bit data memory (24-bit word address, synchronous write, combinational read) between two requesters.
- Requester A is the processor load/store unit; requester B is the DSP sample/coefficient engine.
- Round-robin arbitration, one transaction in flight, fixed 3-cycle transaction sequence; drives the memory's Address/WriteData/WRMEM/RDMEM and captures ReadData.

---
 rtl/dmem_port_arbiter_if.sv | 59 +++++
 rtl/dmem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// The a_err/b_err lines exist only when DMEM_ARB_ADDR_CHECK_EN is defined.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wrmem;
    logic              mem_rdmem;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              gnt_b;
`ifdef DMEM_ARB_ADDR_CHECK_EN
    logic              a_err;
    logic              b_err;
`endif

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output mem_addr, mem_wdata, mem_wrmem, mem_rdmem,
        input  mem_rdata,
`ifdef DMEM_ARB_ADDR_CHECK_EN
        output a_err, b_err,
`endif
        output busy, gnt_b
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  mem_addr, mem_wdata, mem_wrmem, mem_rdmem,
        output mem_rdata,
`ifdef DMEM_ARB_ADDR_CHECK_EN
        input  a_err, b_err,
`endif
        input  busy, gnt_b
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the LSU (A) and DSP engine (B).
// Optional out-of-range address check: define DMEM_ARB_ADDR_CHECK_EN.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | sample a_req/b_req, latch the winner's fields
//  S_ACCESS | drive memory strobes from latched fields; write/read at exit edge
//  S_RESP   | pulse winner's ack, update last-grant pointer
module dmem_port_arbiter #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1025
) (
    input logic                   Clk,
    input logic                   Rst_n,
    dmem_port_arbiter_if.slave    bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        state;
    logic              last_b;
    logic              gnt_b_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    logic              grant_any;
    logic              grant_b;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              oor;
    logic [DATA_W-1:0] rd_val;

    always_comb begin
        grant_any = bus.a_req | bus.b_req;
        // On a tie, the requester that did not own the last transaction wins
        if (bus.a_req && bus.b_req)
            grant_b = ~last_b;
        else
            grant_b = bus.b_req;
        sel_we    = grant_b ? bus.b_we    : bus.a_we;
        sel_addr  = grant_b ? bus.b_addr  : bus.a_addr;
        sel_wdata = grant_b ? bus.b_wdata : bus.a_wdata;
    end

`ifdef DMEM_ARB_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

    logic oor_q;
    logic oor_next;

    assign oor_next = ({1'b0, sel_addr} >= DEPTH_L);
    assign oor      = oor_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            oor_q <= 1'b0;
        else if (state == S_IDLE && grant_any)
            oor_q <= oor_next;
    end

    assign bus.a_err = (state == S_RESP) & ~gnt_b_q & oor_q;
    assign bus.b_err = (state == S_RESP) &  gnt_b_q & oor_q;
`else
    assign oor = 1'b0;
`endif

    assign rd_val = oor ? '0 : bus.mem_rdata;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= S_IDLE;
            last_b    <= 1'b1;
            gnt_b_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        gnt_b_q <= grant_b;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!we_q) begin
                        if (gnt_b_q)
                            b_rdata_q <= rd_val;
                        else
                            a_rdata_q <= rd_val;
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    last_b <= gnt_b_q;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so they fall the instant reset asserts
    assign bus.mem_wrmem = (state == S_ACCESS) &  we_q & ~oor;
    assign bus.mem_rdmem = (state == S_ACCESS) & ~we_q & ~oor;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.a_ack   = (state == S_RESP) & ~gnt_b_q;
    assign bus.b_ack   = (state == S_RESP) &  gnt_b_q;
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_rdata = b_rdata_q;
    assign bus.busy    = (state == S_ACCESS) || (state == S_RESP);
    assign bus.gnt_b   = gnt_b_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: vector table of single transactions plus
// hand-written tie, fairness, dropped-request, mid-access reset and address-check sequences.
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(24), .DATA_W(32)) bus ();

    dmem_port_arbiter #(.ADDR_W(24), .DATA_W(32), .MEM_DEPTH(1025)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] mem [0:2047];
    assign bus.mem_rdata = mem[bus.mem_addr[10:0]];
    always @(posedge clk)
        if (bus.mem_wrmem) mem[bus.mem_addr[10:0]] <= bus.mem_wdata;

    int wr_pulses = 0;
    logic both_strobes = 1'b0;
    always @(posedge clk) if (bus.mem_wrmem) wr_pulses++;
    always @(negedge clk) if (bus.mem_wrmem && bus.mem_rdmem) both_strobes = 1'b1;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One transaction from IDLE; request dropped in the ack cycle
    task automatic txn(input string name, input logic is_b, input logic we,
                       input logic [23:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err);
        int lat = 0, own = 0, other = 0, wr0;
        logic [31:0] rd = '0;
        logic g = 1'b0, e = 1'b0, bz = 1'b0;
        wr0 = wr_pulses;
        if (is_b) begin
            bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata; bus.b_req = 1;
        end else begin
            bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata; bus.a_req = 1;
        end
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (is_b ? bus.b_ack : bus.a_ack) begin
                own++;
                if (lat == 0) begin
                    lat = c;
                    rd  = is_b ? bus.b_rdata : bus.a_rdata;
                    g   = bus.gnt_b;
                    bz  = bus.busy;
`ifdef DMEM_ARB_ADDR_CHECK_EN
                    e   = is_b ? bus.b_err : bus.a_err;
`endif
                end
                if (is_b) bus.b_req = 0; else bus.a_req = 0;
            end
            if (is_b ? bus.a_ack : bus.b_ack) other++;
        end
        check({name, " ack_latency"}, lat, 2);
        check({name, " ack_count"}, own, 1);
        check({name, " other_ack"}, other, 0);
        check({name, " rdata"}, rd, exp_rd);
        check({name, " gnt_b"}, {31'b0, g}, {31'b0, is_b});
        check({name, " busy_in_resp"}, {31'b0, bz}, 32'd1);
        check({name, " wr_pulses"}, wr_pulses - wr0, (we && !exp_err) ? 1 : 0);
`ifdef DMEM_ARB_ADDR_CHECK_EN
        check({name, " err"}, {31'b0, e}, {31'b0, exp_err});
`else
        check({name, " err_unused"}, {31'b0, e}, {31'b0, exp_err});
`endif
    endtask

    typedef struct {
        string       name;
        logic        is_b;
        logic        we;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int n, last, a_c, b_c;
        logic who;
        logic [31:0] ra, rb;

        vecs[0] = '{"A_wr_10",  1'b0, 1'b1, 24'h000010, 32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{"A_rd_10",  1'b0, 1'b0, 24'h000010, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{"B_wr_3FE", 1'b1, 1'b1, 24'h0003FE, 32'hCAFEF00D, 32'h00000000};
        vecs[3] = '{"B_rd_3FE", 1'b1, 1'b0, 24'h0003FE, 32'h0,        32'hCAFEF00D};
        vecs[4] = '{"A_wr_11",  1'b0, 1'b1, 24'h000011, 32'h01234567, 32'hDEADBEEF};
        vecs[5] = '{"B_rd_10",  1'b1, 1'b0, 24'h000010, 32'h0,        32'hDEADBEEF};
        vecs[6] = '{"A_rd_11",  1'b0, 1'b0, 24'h000011, 32'h0,        32'h01234567};
        vecs[7] = '{"B_wr_0",   1'b1, 1'b1, 24'h000000, 32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[8] = '{"A_rd_0",   1'b0, 1'b0, 24'h000000, 32'h0,        32'hFFFFFFFF};

        for (int i = 0; i < 2048; i++) mem[i] = '0;
        idle_inputs();
        #1;
        check("rst busy",   {31'b0, bus.busy},      0);
        check("rst gnt_b",  {31'b0, bus.gnt_b},     0);
        check("rst a_ack",  {31'b0, bus.a_ack},     0);
        check("rst b_ack",  {31'b0, bus.b_ack},     0);
        check("rst wrmem",  {31'b0, bus.mem_wrmem}, 0);
        check("rst rdmem",  {31'b0, bus.mem_rdmem}, 0);
        check("rst addr",   {8'b0, bus.mem_addr},   0);
        check("rst a_rdata", bus.a_rdata,           0);
        do_reset();

        for (int i = 0; i < 9; i++)
            txn(vecs[i].name, vecs[i].is_b, vecs[i].we, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_rd, 1'b0);

        // Simultaneous requests after reset: A first, B three cycles later
        do_reset();
        mem[5] = 32'h11111111;
        mem[6] = 32'h22222222;
        bus.a_addr = 24'h5; bus.b_addr = 24'h6; bus.a_req = 1; bus.b_req = 1;
        a_c = 0; b_c = 0; ra = '0; rb = '0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (bus.a_ack && a_c == 0) begin a_c = c; ra = bus.a_rdata; bus.a_req = 0; end
            if (bus.b_ack && b_c == 0) begin b_c = c; rb = bus.b_rdata; bus.b_req = 0; end
        end
        check("tie a_ack_cycle", a_c, 2);
        check("tie a_rdata", ra, 32'h11111111);
        check("tie b_ack_cycle", b_c, 5);
        check("tie b_rdata", rb, 32'h22222222);

        // Continuous requests from both: strict alternation, 3-cycle spacing
        do_reset();
        bus.a_addr = 24'h5; bus.b_addr = 24'h6; bus.a_req = 1; bus.b_req = 1;
        n = 0; last = 0;
        for (int c = 1; c <= 40 && n < 6; c++) begin
            @(posedge clk); #1;
            if (bus.a_ack || bus.b_ack) begin
                who = bus.b_ack;
                check($sformatf("rr owner_%0d", n), {31'b0, who}, n % 2);
                check($sformatf("rr gnt_b_%0d", n), {31'b0, bus.gnt_b}, n % 2);
                check($sformatf("rr spacing_%0d", n), c - last, (n == 0) ? 2 : 3);
                last = c;
                n++;
                if (n == 6) begin bus.a_req = 0; bus.b_req = 0; end
            end
        end
        check("rr txn_count", n, 6);
        bus.a_req = 0; bus.b_req = 0;
        repeat (3) @(posedge clk); #1;

        // B write with request withdrawn during ACCESS
        begin
            int wr0, acks;
            wr0 = wr_pulses; acks = 0;
            bus.b_we = 1; bus.b_addr = 24'h3FF; bus.b_wdata = 32'h12345678; bus.b_req = 1;
            @(posedge clk); #1;
            check("drop in_access", {31'b0, bus.mem_wrmem}, 1);
            bus.b_req = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (bus.b_ack) acks++;
            end
            check("drop b_ack_count", acks, 1);
            check("drop wr_pulses", wr_pulses - wr0, 1);
            bus.b_we = 0;
        end
        txn("A_rd_3FF", 1'b0, 1'b0, 24'h3FF, 32'h0, 32'h12345678, 1'b0);

        // Reset asserted mid-ACCESS of an A write
        do_reset();
        mem[32'h20] = 32'hAAAAAAAA;
        begin
            int acks = 0;
            bus.a_we = 1; bus.a_addr = 24'h20; bus.a_wdata = 32'h55555555; bus.a_req = 1;
            @(posedge clk); #1;
            check("rstmid in_access", {31'b0, bus.mem_wrmem}, 1);
            #2 rst_n = 1'b0; bus.a_req = 0;
            #1;
            check("rstmid wrmem", {31'b0, bus.mem_wrmem}, 0);
            check("rstmid rdmem", {31'b0, bus.mem_rdmem}, 0);
            check("rstmid busy",  {31'b0, bus.busy},      0);
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                if (bus.a_ack) acks++;
            end
            rst_n = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                if (bus.a_ack) acks++;
            end
            check("rstmid no_ack", acks, 0);
            check("rstmid mem_20", mem[32'h20], 32'hAAAAAAAA);
            bus.a_we = 0; bus.a_addr = 24'h5; bus.b_addr = 24'h6;
            bus.a_req = 1; bus.b_req = 1;
            a_c = 0;
            for (int c = 1; c <= 4 && a_c == 0; c++) begin
                @(posedge clk); #1;
                if (bus.a_ack || bus.b_ack) a_c = bus.b_ack ? 2 : 1;
            end
            check("rstmid first_owner_A", a_c, 1);
            bus.a_req = 0; bus.b_req = 0;
            repeat (6) @(posedge clk); #1;
        end

`ifdef DMEM_ARB_ADDR_CHECK_EN
        txn("A_wr_401_oor", 1'b0, 1'b1, 24'h000401, 32'h0BADF00D, 32'h11111111, 1'b1);
        check("oor mem_401", mem[32'h401], 32'h0);
        txn("A_rd_401_oor", 1'b0, 1'b0, 24'h000401, 32'h0, 32'h0, 1'b1);
        txn("B_rd_400_in",  1'b1, 1'b0, 24'h000400, 32'h0, 32'h0, 1'b0);
`endif

        check("strobes_exclusive", {31'b0, both_strobes}, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
